// File: rtl/npu_feed_pkg.sv
// Shared types and defaults for the unified-buffer to systolic-array feed path.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package npu_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feed_state_t;

    localparam int unsigned FEED_LEN_WIDTH = 16;

endpackage

// File: rtl/feed_lane_skew.sv
// Triangular en-gated delay line: lane i of a consumed row sees i+1 register stages.
// Lane-0 first/last tags travel alongside lane 0.
module feed_lane_skew
    import npu_feed_pkg::*;
#(
    parameter int unsigned N          = `ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [N*DATA_WIDTH-1:0] data_in,
    input  logic                    first_in,
    input  logic                    last_in,
    output logic [N*DATA_WIDTH-1:0] data_out,
    output logic [N-1:0]            lane_valid,
    output logic                    first_out,
    output logic                    last_out
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] d_q [i+1];
        logic                  v_q [i+1];

        // invalid lanes carry zero data so the outputs stay clean
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= i; k++) begin
                    d_q[k] <= '0;
                    v_q[k] <= 1'b0;
                end
            end else if (en) begin
                d_q[0] <= in_valid ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                v_q[0] <= in_valid;
                for (int k = 1; k <= i; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = d_q[i];
        assign lane_valid[i]                        = v_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (en) begin
            first_out <= in_valid & first_in;
            last_out  <= in_valid & last_in;
        end
    end

endmodule

// File: rtl/ub_stream_feeder.sv
// Streams an L-row tile from the unified buffer on NUM_CH strided channels,
// replaying the last read on stalls and skewing each row across the array lanes.
module ub_stream_feeder
    import npu_feed_pkg::*;
#(
    parameter int unsigned N          = `ARRAY_SIZE,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned LEN_WIDTH  = FEED_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           length,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   base_addr_flat,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   stride_flat,
    output logic [NUM_CH*ADDR_WIDTH-1:0]   ub_addr_flat,
    output logic [NUM_CH-1:0]              ub_first_flat,
    output logic [NUM_CH-1:0]              ub_last_flat,
    input  logic [NUM_CH*N*DATA_WIDTH-1:0] ub_data_flat,
    input  logic [NUM_CH-1:0]              ub_first_ret_flat,
    input  logic [NUM_CH-1:0]              ub_last_ret_flat,
    output logic [NUM_CH*N*DATA_WIDTH-1:0] data_flat,
    output logic [NUM_CH*N-1:0]            lane_valid_flat,
    output logic [NUM_CH-1:0]              first_out,
    output logic [NUM_CH-1:0]              last_out,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned LANE_W = N * DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(N + 2);

    feed_state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]        len_q, row_q;
    logic [CNT_W-1:0]            drain_q;
    logic [NUM_CH*ADDR_WIDTH-1:0] ptr_q, stride_q, rec_addr_q;
    logic [NUM_CH-1:0]           rec_first_q, rec_last_q;
    logic                        ret_valid_q, busy_q, done_q, done_d;
    logic                        row_first_c, row_last_c, issue_valid_c;
    logic                        start_tile_c, drain_end_c;

    assign row_first_c  = (row_q == '0);
    assign row_last_c   = (row_q == len_q - LEN_WIDTH'(1));
    assign start_tile_c = (state_q == IDLE) && start && (length != '0);
    assign drain_end_c  = (state_q == DRAIN) && en && (drain_q == CNT_W'(N));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) state_d = STREAM;
                    else              done_d  = 1'b1;
                end
            end
            STREAM: begin
                if (en && row_last_c) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_end_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Live issue when advancing in STREAM; a stall re-presents the recorded issue
    // so the UB reproduces the data that was not consumed.
    always_comb begin
        ub_addr_flat  = rec_addr_q;
        ub_first_flat = '0;
        ub_last_flat  = '0;
        issue_valid_c = 1'b0;
        if (!en) begin
            ub_first_flat = rec_first_q;
            ub_last_flat  = rec_last_q;
        end else if (state_q == STREAM) begin
            ub_addr_flat  = ptr_q;
            ub_first_flat = {NUM_CH{row_first_c}};
            ub_last_flat  = {NUM_CH{row_last_c}};
            issue_valid_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    // Tile parameters and per-channel address walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            row_q    <= '0;
            ptr_q    <= '0;
            stride_q <= '0;
        end else if (start_tile_c) begin
            len_q    <= length;
            row_q    <= '0;
            ptr_q    <= base_addr_flat;
            stride_q <= stride_flat;
        end else if ((state_q == STREAM) && en) begin
            row_q <= row_q + LEN_WIDTH'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c*ADDR_WIDTH +: ADDR_WIDTH] <= ptr_q[c*ADDR_WIDTH +: ADDR_WIDTH]
                                                   + stride_q[c*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Replay record and the valid that lines up with the UB return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_addr_q  <= '0;
            rec_first_q <= '0;
            rec_last_q  <= '0;
            ret_valid_q <= 1'b0;
        end else if (en) begin
            rec_addr_q  <= ub_addr_flat;
            rec_first_q <= ub_first_flat;
            rec_last_q  <= ub_last_flat;
            ret_valid_q <= issue_valid_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= '0;
        end else if ((state_q != DRAIN) || drain_end_c) begin
            drain_q <= '0;
        end else if (en) begin
            drain_q <= drain_q + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        feed_lane_skew #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .in_valid   (ret_valid_q),
            .data_in    (ub_data_flat[c*LANE_W +: LANE_W]),
            .first_in   (ub_first_ret_flat[c]),
            .last_in    (ub_last_ret_flat[c]),
            .data_out   (data_flat[c*LANE_W +: LANE_W]),
            .lane_valid (lane_valid_flat[c*N +: N]),
            .first_out  (first_out[c]),
            .last_out   (last_out[c])
        );
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
